// File: rtl/scirc_share_arb.sv
// scirc_share_arb
//   Round-robin sharing of one 2-bit-input scirc datapath between two
//   symbol requesters. Each burst owner gets a freshly reset datapath,
//   and every y result comes back tagged with the requester that produced it.
//   Optional feature macro: SCIRC_ARB_BURST_LIMIT_EN (per-burst symbol limit
//   with a sticky err_o on forced termination).
module scirc_share_arb #(
    parameter int SYM_W     = 2,
    parameter int DP_LAT    = 1,
    parameter int CLR_CYC   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         req_valid_i,
    input  logic [1:0]         req_last_i,
    input  logic [2*SYM_W-1:0] req_x_i,
    output logic [1:0]         req_ready_o,
    output logic [SYM_W-1:0]   dp_x_o,
    output logic               dp_ce_o,
    output logic               dp_rst_o,
    input  logic               dp_y_i,
    output logic               y_valid_o,
    output logic               y_o,
    output logic               y_owner_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    logic [1:0]       state;
    logic             owner;
    logic             rr_last;
    logic [CLR_W-1:0] clr_cnt;

    logic [DP_LAT:0]  pipe_v;
    logic [DP_LAT:0]  pipe_own;

    logic             grant_idx;
    logic             accept;
    logic             last_in;
    logic [SYM_W-1:0] sym;
    logic             force_last;
    logic             end_burst;
    logic             pipe_empty;

    // Both valid: the requester that did not own the previous burst wins.
    // Otherwise the single valid requester wins (index is simply valid[1]).
    assign grant_idx  = (req_valid_i == 2'b11) ? ~rr_last : req_valid_i[1];

    assign sym        = owner ? req_x_i[2*SYM_W-1:SYM_W] : req_x_i[SYM_W-1:0];
    assign last_in    = req_last_i[owner];
    assign accept     = (state == ST_STREAM) & req_valid_i[owner];
    assign end_burst  = accept & (last_in | force_last);
    assign pipe_empty = ~|pipe_v;

    assign req_ready_o = (state != ST_STREAM) ? 2'b00 :
                         (owner ? 2'b10 : 2'b01);
    // Reset reaches the datapath combinationally so it is cleared the moment
    // rst_i falls, not one edge later.
    assign dp_rst_o    = rst_i & (state != ST_CLEAR);
    assign busy_o      = (state != ST_IDLE);

    // Burst sequencing: grant, clear the datapath, stream, wait for results.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            owner   <= 1'b0;
            rr_last <= 1'b1;
            clr_cnt <= '0;
        end else begin
            // NOTE: every register here uses <= so all blocks see pre-edge values,
            // which is what keeps accept/pipe/FSM updates consistent in one cycle.
            case (state)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        owner   <= grant_idx;
                        clr_cnt <= '0;
                        state   <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == CLR_W'(CLR_CYC - 1)) begin
                        state <= ST_STREAM;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (end_burst) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        rr_last <= owner;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath drive: one clock-enable strobe per accepted symbol, x held in gaps.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dp_x_o  <= '0;
            dp_ce_o <= 1'b0;
        end else begin
            dp_ce_o <= accept;
            if (accept) begin
                dp_x_o <= sym;
            end
        end
    end

    // Result tracking: valid/owner tokens walk alongside the datapath latency.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: this small pipe is reset on purpose; a reset must drop any
        // in-flight result, so leaving it uninitialised is not an option.
        if (!rst_i) begin
            pipe_v   <= '0;
            pipe_own <= '0;
        end else begin
            pipe_v[0]   <= accept;
            pipe_own[0] <= owner;
            for (int i = 1; i <= DP_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    // Result capture: sample dp_y_i when the token leaves the pipe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            y_valid_o <= 1'b0;
            y_o       <= 1'b0;
            y_owner_o <= 1'b0;
        end else begin
            y_valid_o <= pipe_v[DP_LAT];
            if (pipe_v[DP_LAT]) begin
                y_o       <= dp_y_i;
                y_owner_o <= pipe_own[DP_LAT];
            end
        end
    end

`ifdef SCIRC_ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] burst_cnt;
    logic             err_q;

    // The MAX_BURST-th symbol without last closes the burst anyway.
    assign force_last = ~last_in & (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign err_o      = err_q;

    // Per-burst accept count and sticky forced-termination flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            burst_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                burst_cnt <= '0;
            end else if (accept) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
            if (accept & force_last) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign force_last = 1'b0;
    // Bursts are unbounded here; MAX_BURST is always positive, so err_o is a constant 0.
    assign err_o      = (MAX_BURST < 0);
`endif

endmodule

// File: tb/tb_scirc_share_arb.sv
// tb_scirc_share_arb
//   Directed bench for scirc_share_arb with a small scirc reference datapath
//   (2-bit accumulator s += x, y = s[1], reset by dp_rst_o).
//   Exercises test 6 only when SCIRC_ARB_BURST_LIMIT_EN is defined.
module tb_scirc_share_arb;

    localparam int SYM_W     = 2;
    localparam int DP_LAT    = 1;
    localparam int CLR_CYC   = 1;
    localparam int MAX_BURST = 4;
    localparam int LAT       = DP_LAT + 2;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [1:0] req_valid;
    logic [1:0] req_last;
    logic [3:0] req_x;
    logic [1:0] req_ready;
    logic [1:0] dp_x;
    logic       dp_ce;
    logic       dp_rst;
    logic       dp_y;
    logic       y_valid;
    logic       y;
    logic       y_owner;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    scirc_share_arb #(
        .SYM_W    (SYM_W),
        .DP_LAT   (DP_LAT),
        .CLR_CYC  (CLR_CYC),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_valid_i(req_valid),
        .req_last_i (req_last),
        .req_x_i    (req_x),
        .req_ready_o(req_ready),
        .dp_x_o     (dp_x),
        .dp_ce_o    (dp_ce),
        .dp_rst_o   (dp_rst),
        .dp_y_i     (dp_y),
        .y_valid_o  (y_valid),
        .y_o        (y),
        .y_owner_o  (y_owner),
        .busy_o     (busy),
        .err_o      (err)
    );

    // Reference scirc datapath
    logic [1:0] dp_s;
    always_ff @(posedge clk) begin
        if (!dp_rst) dp_s <= 2'd0;
        else if (dp_ce) dp_s <= dp_s + dp_x;
    end
    assign dp_y = dp_s[1];

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge
    int         res_cyc[$];
    logic       res_y[$];
    logic       res_own[$];
    logic [1:0] strobe_x[$];
    int         acc_cyc[$];
    int         clr_low = 0;

    always @(negedge clk) begin
        if (rst_i) begin
            if (y_valid) begin
                res_cyc.push_back(cyc);
                res_y.push_back(y);
                res_own.push_back(y_owner);
            end
            if (dp_ce) strobe_x.push_back(dp_x);
            if (!dp_rst) clr_low++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_log();
        res_cyc.delete();
        res_y.delete();
        res_own.delete();
        strobe_x.delete();
        acc_cyc.delete();
        clr_low = 0;
    endtask

    // Present one symbol and hold it until accepted (bounded).
    task automatic send(input int who, input logic [1:0] x, input logic last);
        req_valid[who]      = 1'b1;
        req_x[who*2 +: 2]   = x;
        req_last[who]       = last;
        for (int n = 0; n < 20; n++) begin
            if (req_ready[who]) begin
                check("ready_other_low", req_ready[1-who], 1'b0);
                acc_cyc.push_back(cyc);
                tick();
                return;
            end
            tick();
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40; n++) begin
            if (!busy) return;
            tick();
        end
        check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_results(input string tag, input int n, input logic [7:0] ys,
                                 input logic [7:0] owns);
        check({tag, "_count"}, res_y.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < res_y.size() && i < acc_cyc.size()) begin
                check({tag, "_y"}, res_y[i], ys[i]);
                check({tag, "_owner"}, res_own[i], owns[i]);
                check({tag, "_lat"}, res_cyc[i] - acc_cyc[i], LAT);
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b0;
        repeat (n) tick();
        rst_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i     = 1'b1;
        req_valid = 2'b00;
        req_last  = 2'b00;
        req_x     = 4'h0;
        #1 rst_i  = 1'b0;

        // 1. Reset
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  {req_ready, dp_x, dp_ce, dp_rst, y_valid, y, y_owner, busy, err}, 11'd0);
        end
        rst_i = 1'b1;
        #1;
        check("release_dp_rst", dp_rst, 1'b1);
        check("release_busy", busy, 1'b0);

        // 2. Solo burst 00,11,01: y = 0,1,0
        clear_log();
        send(0, 2'b00, 1'b0);
        send(0, 2'b11, 1'b0);
        send(0, 2'b01, 1'b1);
        req_valid[0] = 1'b0;
        wait_idle();
        check_results("solo", 3, 8'b010, 8'b000);
        check("solo_strobes", strobe_x.size(), 3);
        if (strobe_x.size() == 3) begin
            check("solo_x0", strobe_x[0], 2'b00);
            check("solo_x1", strobe_x[1], 2'b11);
            check("solo_x2", strobe_x[2], 2'b01);
        end
        check("solo_clr_cycles", clr_low, CLR_CYC);

        // 3. Contention after reset: req0 first (01,10 -> y 0,1),
        //    then req1 on a cleared datapath (11,11 -> y 1,1).
        do_reset(2);
        clear_log();
        req_valid = 2'b11;
        req_x     = {2'b11, 2'b01};
        req_last  = 2'b00;
        send(0, 2'b01, 1'b0);
        send(0, 2'b10, 1'b1);
        req_valid[0] = 1'b0;
        send(1, 2'b11, 1'b0);
        send(1, 2'b11, 1'b1);
        req_valid[1] = 1'b0;
        wait_idle();
        check_results("contend", 4, 8'b1110, 8'b1100);
        check("contend_clr_cycles", clr_low, 2 * CLR_CYC);
        check("contend_err", err, 1'b0);

        // 4. Gaps: req1 sends 10, idles, then 00(last): y = 1,1
        clear_log();
        send(1, 2'b10, 1'b0);
        req_valid[1] = 1'b0;
        check("gap_strobe", dp_ce, 1'b1);
        repeat (3) begin
            tick();
            check("gap_ce_low", dp_ce, 1'b0);
            check("gap_x_hold", dp_x, 2'b10);
        end
        send(1, 2'b00, 1'b1);
        req_valid[1] = 1'b0;
        wait_idle();
        check_results("gap", 2, 8'b11, 8'b11);

        // 5. Mid-burst reset during req0's second symbol
        clear_log();
        send(0, 2'b11, 1'b0);
        req_x[1:0] = 2'b01;
        rst_i = 1'b0;
        #1;
        check("midrst_dp_rst", dp_rst, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", req_ready, 2'b00);
        @(negedge clk);
        tick();
        rst_i        = 1'b1;
        req_valid[0] = 1'b0;
        #1;
        check("midrst_idle", busy, 1'b0);
        clear_log();
        send(1, 2'b01, 1'b1);
        req_valid[1] = 1'b0;
        wait_idle();
        check_results("midrst", 1, 8'b0, 8'b1);

`ifdef SCIRC_ARB_BURST_LIMIT_EN
        // 6. Burst limit 4: req0 forced into DRAIN, req1 served next.
        do_reset(2);
        clear_log();
        req_valid[1] = 1'b1;
        req_x[3:2]   = 2'b10;
        req_last[1]  = 1'b1;
        send(0, 2'b01, 1'b0);
        send(0, 2'b10, 1'b0);
        send(0, 2'b11, 1'b0);
        send(0, 2'b00, 1'b0);
        req_x[1:0] = 2'b01;
        check("limit_ready_drop", req_ready[0], 1'b0);
        check("limit_err", err, 1'b1);
        send(1, 2'b10, 1'b1);
        req_valid = 2'b00;
        wait_idle();
        check_results("limit", 5, 8'b11110, 8'b10000);
        check("limit_err_sticky", err, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
